// File: rtl/lmnn_fwd_pkg.sv
// Shared FSM encoding, layer-size width and lane-mask helper for the layer forward path.
// Pure definitions: no latency, no flow control.
package lmnn_fwd_pkg;

    localparam int LAYER_SIZE_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A size of zero or one beyond the physical lanes means "use every lane".
    function automatic logic lane_enabled(input logic [LAYER_SIZE_W-1:0] count,
                                          input int lane, input int num_lanes);
        int eff;
        eff = int'(count);
        if (eff == 0 || eff > num_lanes) begin
            eff = num_lanes;
        end
        return lane < eff;
    endfunction

endpackage

// File: rtl/active_mask_gen.sv
// Lane count -> clamped low-lane enable mask.
// Combinational, zero latency, no flow control.
module active_mask_gen
    import lmnn_fwd_pkg::*;
#(
    parameter int NUM_NEURON = 6
) (
    input  logic [LAYER_SIZE_W-1:0] count,
    output logic [NUM_NEURON-1:0]   mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_NEURON; i++) begin
            mask[i] = lane_enabled(count, i, NUM_NEURON);
        end
    end

endmodule

// File: rtl/layer_input_scheduler.sv
// Sequences one sample through LAYER_MAX neuron layers, feeding each layer's outputs back as operands.
// Capture no earlier than SETTLE_CYCLES+1 after launch; sample accepted only in IDLE, result held until result_ready.
module layer_input_scheduler
    import lmnn_fwd_pkg::*;
#(
    parameter int LAYER_MAX      = 3,
    parameter int NUM_NEURON     = 6,
    parameter int INPUT_SIZE     = 9,
    parameter logic [LAYER_MAX*LAYER_SIZE_W-1:0] LAYER_SIZES = {8'd2, 8'd4, 8'd6},
    parameter int SETTLE_CYCLES  = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_NEURON*INPUT_SIZE-1:0]     in_data,
    input  logic [NUM_NEURON*INPUT_SIZE-1:0]     layer_data,
    input  logic [NUM_NEURON-1:0]                layer_valid,
    output logic [NUM_NEURON*INPUT_SIZE-1:0]     out_inputs,
    output logic [NUM_NEURON-1:0]                active,
    output logic                                 layer_start,
    output logic [$clog2(LAYER_MAX+1)-1:0]       layer,
    output logic                                 result_valid,
    output logic [NUM_NEURON*INPUT_SIZE-1:0]     result_data,
    input  logic                                 result_ready,
    output logic                                 timeout_err
);

    localparam int LW   = $clog2(LAYER_MAX + 1);
    localparam int DW   = NUM_NEURON * INPUT_SIZE;
    localparam int TMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    // One spare bit keeps the saturation point strictly above any compare threshold.
    localparam int TW   = $clog2(TMAX + 1) + 1;

    logic [1:0]              state;
    logic [TW-1:0]           timer;
    logic [DW-1:0]           operand_buf;
    logic [DW-1:0]           lane_bits;
    logic [LW-1:0]           next_layer;
    logic [LAYER_SIZE_W-1:0] size_sel;
    logic [NUM_NEURON-1:0]   next_mask;
    logic                    capture;
    logic                    timed_out;

    always_comb begin
        next_layer = (state == ST_IDLE) ? '0 : layer + LW'(1);
    end

    always_comb begin
        size_sel = '0;
        for (int i = 0; i < LAYER_MAX; i++) begin
            if (next_layer == LW'(i)) begin
                size_sel = LAYER_SIZES[i*LAYER_SIZE_W +: LAYER_SIZE_W];
            end
        end
    end

    active_mask_gen #(
        .NUM_NEURON (NUM_NEURON)
    ) u_mask (
        .count (size_sel),
        .mask  (next_mask)
    );

    always_comb begin
        lane_bits = '0;
        for (int n = 0; n < NUM_NEURON; n++) begin
            lane_bits[n*INPUT_SIZE +: INPUT_SIZE] = {INPUT_SIZE{active[n]}};
        end
    end

    // Capture beats timeout when both are true in the same cycle.
    always_comb begin
        capture   = (state == ST_WAIT) && (timer >= TW'(SETTLE_CYCLES))
                    && ((layer_valid & active) == active);
        timed_out = (state == ST_WAIT) && !capture && (timer >= TW'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            layer       <= '0;
            active      <= '0;
            operand_buf <= '0;
            timer       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        operand_buf <= in_data;
                        layer       <= '0;
                        active      <= next_mask;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (timer != '1) begin
                        timer <= timer + TW'(1);
                    end
                    if (capture) begin
                        operand_buf <= layer_data & lane_bits;
                        if (layer == LW'(LAYER_MAX - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            layer  <= next_layer;
                            active <= next_mask;
                            state  <= ST_LAUNCH;
                        end
                    end else if (timed_out) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state == ST_IDLE);
        layer_start  = (state == ST_LAUNCH);
        result_valid = (state == ST_DONE);
        result_data  = operand_buf;
        out_inputs   = operand_buf & lane_bits;
        timeout_err  = timed_out;
    end

endmodule

// File: tb/tb_layer_input_scheduler.sv
// Directed bench for layer_input_scheduler with a per-cycle reference model and literal spot checks.
module tb_layer_input_scheduler;

    localparam int NN     = 6;
    localparam int IS     = 9;
    localparam int DW     = NN * IS;
    localparam int LM     = 3;
    localparam int SETTLE = 6;
    localparam int TMO    = 20;

    localparam int M_IDLE   = 0;
    localparam int M_LAUNCH = 1;
    localparam int M_WAIT   = 2;
    localparam int M_DONE   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] layer_data;
    logic [NN-1:0] layer_valid;
    logic [DW-1:0] out_inputs;
    logic [NN-1:0] active;
    logic          layer_start;
    logic [1:0]    layer;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic          result_ready;
    logic          timeout_err;

    always #5 clk = ~clk;

    layer_input_scheduler #(
        .LAYER_MAX      (LM),
        .NUM_NEURON     (NN),
        .INPUT_SIZE     (IS),
        .LAYER_SIZES    ({8'd2, 8'd4, 8'd6}),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .layer_data   (layer_data),
        .layer_valid  (layer_valid),
        .out_inputs   (out_inputs),
        .active       (active),
        .layer_start  (layer_start),
        .layer        (layer),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_ready (result_ready),
        .timeout_err  (timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int size_of(input int l);
        case (l)
            0:       return 6;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int lane_of(input logic [DW-1:0] vec, input int n);
        return int'(vec[n*IS +: IS]);
    endfunction

    function automatic logic [DW-1:0] lanes6(input int a0, input int a1, input int a2,
                                             input int a3, input int a4, input int a5);
        logic [DW-1:0] v;
        v = '0;
        v[0*IS +: IS] = IS'(a0);
        v[1*IS +: IS] = IS'(a1);
        v[2*IS +: IS] = IS'(a2);
        v[3*IS +: IS] = IS'(a3);
        v[4*IS +: IS] = IS'(a4);
        v[5*IS +: IS] = IS'(a5);
        return v;
    endfunction

    // Reference model: stage, layer, cycles since the launch cycle, operand lanes, active lane count.
    bit m_valid    = 1'b0;
    int m_mode     = M_IDLE;
    int m_layer    = 0;
    int m_since    = 0;
    int m_act      = 0;
    int m_launches = 0;
    int m_ops[NN];

    function automatic logic [DW-1:0] model_ops(input int cnt);
        logic [DW-1:0] v;
        v = '0;
        for (int n = 0; n < NN; n++) begin
            if (n < cnt) v[n*IS +: IS] = IS'(m_ops[n]);
        end
        return v;
    endfunction

    always @(negedge clk) begin : compare
        int  amask;
        bit  cap;
        bit  tmo;
        amask = (1 << m_act) - 1;
        cap = (m_mode == M_WAIT) && (m_since >= SETTLE + 1)
              && ((int'(layer_valid) & amask) == amask);
        tmo = (m_mode == M_WAIT) && !cap && (m_since >= TMO + 1);
        if (m_valid) begin
            chk("in_ready",     in_ready,     m_mode == M_IDLE);
            chk("layer_start",  layer_start,  m_mode == M_LAUNCH);
            chk("result_valid", result_valid, m_mode == M_DONE);
            chk("timeout_err",  timeout_err,  tmo);
            chk("layer",        layer,        m_layer);
            chk("active",       active,       amask);
            chk("out_inputs",   out_inputs,   model_ops(m_act));
            if (m_mode == M_DONE) chk("result_data", result_data, model_ops(NN));
        end
        if (rst) begin
            m_valid <= 1'b1;
            m_mode  <= M_IDLE;
            m_layer <= 0;
            m_since <= 0;
            m_act   <= 0;
            for (int n = 0; n < NN; n++) m_ops[n] <= 0;
        end else if (m_valid) begin
            case (m_mode)
                M_IDLE: if (in_valid) begin
                    for (int n = 0; n < NN; n++) m_ops[n] <= lane_of(in_data, n);
                    m_layer    <= 0;
                    m_act      <= size_of(0);
                    m_mode     <= M_LAUNCH;
                    m_launches <= m_launches + 1;
                end
                M_LAUNCH: begin
                    m_mode  <= M_WAIT;
                    m_since <= 1;
                end
                M_WAIT: begin
                    if (cap) begin
                        for (int n = 0; n < NN; n++)
                            m_ops[n] <= (n < m_act) ? lane_of(layer_data, n) : 0;
                        if (m_layer == LM - 1) begin
                            m_mode <= M_DONE;
                        end else begin
                            m_layer    <= m_layer + 1;
                            m_act      <= size_of(m_layer + 1);
                            m_mode     <= M_LAUNCH;
                            m_launches <= m_launches + 1;
                        end
                    end else if (tmo) begin
                        m_mode <= M_IDLE;
                    end else begin
                        m_since <= m_since + 1;
                    end
                end
                default: if (result_ready) m_mode <= M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in a launch cycle: drives `pre` until cycle launch+switch_at, then `post`,
    // and returns in the cycle following the capture (the next launch or DONE).
    task automatic run_layer(input logic [DW-1:0] data, input int switch_at,
                             input logic [NN-1:0] pre, input logic [NN-1:0] post);
        int last;
        last = (switch_at > SETTLE + 1) ? switch_at : SETTLE + 1;
        layer_data  = data;
        layer_valid = pre;
        for (int k = 0; k <= last; k++) begin
            if (k >= switch_at) layer_valid = post;
            tick();
        end
        layer_valid = '0;
    endtask

    task automatic start_pass(input logic [DW-1:0] sample);
        in_data  = sample;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_timeout(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            if (n == 0) begin
                tick();
                if (timeout_err === 1'b1) n = i;
            end
        end
        if (n == 0) chk("timeout_wait_expired", 64'd0, 64'd1);
    endtask

    logic [DW-1:0] d0, d1, d2, sample;
    int            launches_before;
    int            lat;

    initial begin
        d0     = lanes6(10, 11, 12, 13, 14, 15);
        d1     = lanes6(20, 21, 22, 23, 24, 25);
        d2     = lanes6(30, 31, 32, 33, 34, 35);
        sample = lanes6(1, 2, 3, 4, 5, 6);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; layer_data = '0;
        layer_valid = '0; result_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_in_ready",     in_ready,     64'd1);
        chk("reset_active",       active,       64'd0);
        chk("reset_result_valid", result_valid, 64'd0);
        chk("reset_out_inputs",   out_inputs,   64'd0);

        // Full pass, valid arriving exactly at launch+7, then result backpressure.
        launches_before = m_launches;
        start_pass(sample);
        chk("p1_launch0",  layer_start, 64'd1);
        chk("p1_active0",  active,      64'h3F);
        chk("p1_operands", out_inputs,  sample);
        run_layer(d0, 7, 6'h00, 6'h3F);
        chk("p1_launch1",  layer_start, 64'd1);
        chk("p1_active1",  active,      64'h0F);
        chk("p1_feedback", out_inputs,  lanes6(10, 11, 12, 13, 0, 0));
        run_layer(d1, 7, 6'h00, 6'h3F);
        chk("p1_active2",  active,      64'h03);
        run_layer(d2, 7, 6'h00, 6'h3F);
        chk("p1_result_valid", result_valid, 64'd1);
        chk("p1_result_data",  result_data,  lanes6(30, 31, 0, 0, 0, 0));
        chk("p1_launch_count", 64'(m_launches - launches_before), 64'd3);
        in_data  = lanes6(7, 7, 7, 7, 7, 7);
        in_valid = 1'b1;
        repeat (10) tick();
        chk("bp_result_held", result_data, lanes6(30, 31, 0, 0, 0, 0));
        chk("bp_in_ready",    in_ready,    64'd0);
        in_valid     = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("bp_idle_in_ready",     in_ready,     64'd1);
        chk("bp_idle_result_valid", result_valid, 64'd0);

        // Early valid on layer 0, partial valid on layer 1.
        start_pass(lanes6(100, 200, 300, 400, 500, 511));
        run_layer(d0, 2, 6'h00, 6'h3F);
        chk("early_no_premature_capture", layer, 64'd1);
        chk("early_relaunch",             layer_start, 64'd1);
        run_layer(d1, 10, 6'h07, 6'h0F);
        chk("partial_layer2", layer,  64'd2);
        chk("partial_active", active, 64'h03);
        chk("partial_operands", out_inputs, lanes6(20, 21, 0, 0, 0, 0));
        run_layer(d2, 7, 6'h00, 6'h3F);
        chk("p2_result_valid", result_valid, 64'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // Timeout: nothing ever valid.
        start_pass(sample);
        wait_timeout(40, lat);
        chk("timeout_latency", 64'(lat), 64'd21);
        tick();
        chk("timeout_in_ready",    in_ready,    64'd1);
        chk("timeout_single_shot", timeout_err, 64'd0);

        // Reset during layer 1 wait, then a clean pass.
        start_pass(sample);
        run_layer(d0, 7, 6'h00, 6'h3F);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready",     in_ready,     64'd1);
        chk("midrst_active",       active,       64'd0);
        chk("midrst_layer",        layer,        64'd0);
        chk("midrst_out_inputs",   out_inputs,   64'd0);
        chk("midrst_result_valid", result_valid, 64'd0);
        chk("midrst_timeout",      timeout_err,  64'd0);
        start_pass(sample);
        chk("post_rst_launch", layer_start, 64'd1);
        run_layer(d0, 7, 6'h00, 6'h3F);
        run_layer(d1, 7, 6'h00, 6'h3F);
        run_layer(d2, 7, 6'h00, 6'h3F);
        chk("post_rst_result", result_data, lanes6(30, 31, 0, 0, 0, 0));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
